axi_r_tracker: RTL and testbench

- Read-data (R channel) stage directly downstream of the AR issue FSM.
- Records each accepted AR handshake (ID, burst length) in a per-ID table and accepts R beats from the slave.
- Checks beat count and RLAST per ID, forwards beats through a one-deep registered output stage, and issues a one-cycle dealloc pulse per completed burst back to the read ID pool.
- Flags protocol and response errors.

---
 rtl/axi_r_tracker.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_r_tracker.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_r_tracker.sv
// axi_r_tracker: R-channel burst tracker.
// Records each AR handshake per ID, checks beat count and RLAST for every
// R beat, forwards tracked beats through a one-deep registered output stage
// and pulses dealloc_req when a burst completes so the ID can be reissued.
// Optional build macro AXI_R_TRACKER_STATS_EN adds saturating beat/error
// counters (stat_beats, stat_errs).
module axi_r_tracker #(
    parameter int ID_WIDTH   = 4,
    parameter int ID_COUNT   = 1 << ID_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ar_fire,
    input  logic [ID_WIDTH-1:0]   ar_fire_id,
    input  logic [7:0]            ar_fire_len,
    input  logic                  rvalid,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  rready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_err,
    output logic                  dealloc_req,
    output logic [ID_WIDTH-1:0]   dealloc_id,
    output logic                  err_pulse,
    output logic [2:0]            err_code,
    output logic [ID_WIDTH:0]     outstanding
`ifdef AXI_R_TRACKER_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [15:0]           stat_errs
`endif
);

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ID_REUSE = 3'd1,
        ERR_UNEXP_ID = 3'd2,
        ERR_EARLY    = 3'd3,
        ERR_MISSING  = 3'd4,
        ERR_RESP     = 3'd5
    } err_e;

    // Per-ID table views
    logic [ID_COUNT-1:0] busy_vec;
    logic [ID_COUNT-1:0] busy_next_vec;
    logic [7:0]          exp_len_arr  [ID_COUNT];
    logic [7:0]          beat_cnt_arr [ID_COUNT];

    // Beat lookup
    logic       beat_acc;
    logic       lookup_busy;
    logic [7:0] lookup_len;
    logic [7:0] lookup_cnt;
    logic       tracked;
    logic       at_end;
    logic       complete;
    logic       reuse;
    err_e       err_next;

    // Output stage registers
    logic                  out_valid_reg;
    logic [ID_WIDTH-1:0]   out_id_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_last_reg;
    logic                  out_err_reg;
    logic                  dealloc_req_reg;
    logic [ID_WIDTH-1:0]   dealloc_id_reg;
    logic                  err_pulse_reg;
    logic [2:0]            err_code_reg;
    logic [ID_WIDTH:0]     outstanding_reg;
    logic [ID_WIDTH:0]     outstanding_next;

    // The output register can take a beat whenever it is empty or draining.
    assign rready      = !out_valid_reg || out_ready;
    assign beat_acc    = rvalid && rready;
    assign lookup_busy = busy_vec[rid];
    assign lookup_len  = exp_len_arr[rid];
    assign lookup_cnt  = beat_cnt_arr[rid];
    assign tracked     = beat_acc && lookup_busy;
    assign at_end      = (lookup_cnt == lookup_len);
    assign complete    = tracked && (at_end || rlast);
    // A re-AR on an ID that is retiring in the same cycle is legal.
    assign reuse       = ar_fire && busy_vec[ar_fire_id] &&
                         !(complete && (rid == ar_fire_id));

    for (genvar gi = 0; gi < ID_COUNT; gi++) begin : g_entry
        logic       busy_reg;
        logic [7:0] len_reg;
        logic [7:0] cnt_reg;
        logic       ar_hit;
        logic       clr_hit;
        logic       inc_hit;

        assign ar_hit  = ar_fire && (ar_fire_id == ID_WIDTH'(gi));
        assign clr_hit = complete && (rid == ID_WIDTH'(gi));
        assign inc_hit = tracked && (rid == ID_WIDTH'(gi));

        // Entry update: a new AR wins over completion, so retire-then-record.
        always_ff @(posedge clk) begin
            if (!reset) begin
                busy_reg <= 1'b0;
                len_reg  <= '0;
                cnt_reg  <= '0;
            end else if (ar_hit) begin
                busy_reg <= 1'b1;
                len_reg  <= ar_fire_len;
                cnt_reg  <= '0;
            end else if (clr_hit) begin
                busy_reg <= 1'b0;
                len_reg  <= '0;
                cnt_reg  <= '0;
            end else if (inc_hit) begin
                cnt_reg  <= cnt_reg + 8'd1;
            end
        end

        assign busy_vec[gi]      = busy_reg;
        assign exp_len_arr[gi]   = len_reg;
        assign beat_cnt_arr[gi]  = cnt_reg;
        assign busy_next_vec[gi] = ar_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg);
    end

    // Error classification, highest priority first.
    always_comb begin
        err_next = ERR_NONE;
        if (beat_acc && !lookup_busy) begin
            err_next = ERR_UNEXP_ID;
        end else if (tracked && rlast && !at_end) begin
            err_next = ERR_EARLY;
        end else if (tracked && !rlast && at_end) begin
            err_next = ERR_MISSING;
        end else if (tracked && (rresp != 2'b00)) begin
            err_next = ERR_RESP;
        end else if (reuse) begin
            err_next = ERR_ID_REUSE;
        end
    end

    // Busy-entry count as it will stand after this edge.
    always_comb begin
        outstanding_next = '0;
        for (int i = 0; i < ID_COUNT; i++) begin
            outstanding_next = outstanding_next + (ID_WIDTH+1)'(busy_next_vec[i]);
        end
    end

    // Output stage, dealloc and error strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_reg   <= 1'b0;
            out_id_reg      <= '0;
            out_data_reg    <= '0;
            out_last_reg    <= 1'b0;
            out_err_reg     <= 1'b0;
            dealloc_req_reg <= 1'b0;
            dealloc_id_reg  <= '0;
            err_pulse_reg   <= 1'b0;
            err_code_reg    <= '0;
            outstanding_reg <= '0;
        end else begin
            if (tracked) begin
                out_valid_reg <= 1'b1;
                out_id_reg    <= rid;
                out_data_reg  <= rdata;
                out_last_reg  <= at_end;
                out_err_reg   <= (rresp != 2'b00);
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            dealloc_req_reg <= complete;
            if (complete) begin
                dealloc_id_reg <= rid;
            end
            err_pulse_reg   <= (err_next != ERR_NONE);
            err_code_reg    <= err_next;
            outstanding_reg <= outstanding_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_id      = out_id_reg;
    assign out_data    = out_data_reg;
    assign out_last    = out_last_reg;
    assign out_err     = out_err_reg;
    assign dealloc_req = dealloc_req_reg;
    assign dealloc_id  = dealloc_id_reg;
    assign err_pulse   = err_pulse_reg;
    assign err_code    = err_code_reg;
    assign outstanding = outstanding_reg;

`ifdef AXI_R_TRACKER_STATS_EN
    logic [31:0] stat_beats_reg;
    logic [15:0] stat_errs_reg;

    // Saturating counters of tracked beats and error strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_beats_reg <= '0;
            stat_errs_reg  <= '0;
        end else begin
            if (tracked && (stat_beats_reg != '1)) begin
                stat_beats_reg <= stat_beats_reg + 32'd1;
            end
            if ((err_next != ERR_NONE) && (stat_errs_reg != '1)) begin
                stat_errs_reg <= stat_errs_reg + 16'd1;
            end
        end
    end

    assign stat_beats = stat_beats_reg;
    assign stat_errs  = stat_errs_reg;
`endif

endmodule

// File: tb/tb_axi_r_tracker.sv
// Directed self-checking bench for axi_r_tracker.
module tb_axi_r_tracker;

    localparam int IDW = 4;
    localparam int DW  = 32;

    logic           clk;
    logic           reset;
    logic           ar_fire;
    logic [IDW-1:0] ar_fire_id;
    logic [7:0]     ar_fire_len;
    logic           rvalid;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rready;
    logic           out_valid;
    logic           out_ready;
    logic [IDW-1:0] out_id;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic           out_err;
    logic           dealloc_req;
    logic [IDW-1:0] dealloc_id;
    logic           err_pulse;
    logic [2:0]     err_code;
    logic [IDW:0]   outstanding;
`ifdef AXI_R_TRACKER_STATS_EN
    logic [31:0]    stat_beats;
    logic [15:0]    stat_errs;
`endif

    int checks   = 0;
    int failures = 0;

    // Interleaved burst table: ids 2,1,2,1,2
    logic [3:0] il_id   [5] = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    logic       il_last [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    axi_r_tracker #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ar_fire     (ar_fire),
        .ar_fire_id  (ar_fire_id),
        .ar_fire_len (ar_fire_len),
        .rvalid      (rvalid),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rready      (rready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_id      (out_id),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_err     (out_err),
        .dealloc_req (dealloc_req),
        .dealloc_id  (dealloc_id),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .outstanding (outstanding)
`ifdef AXI_R_TRACKER_STATS_EN
        ,
        .stat_beats  (stat_beats),
        .stat_errs   (stat_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ar_fire = 1'b0; ar_fire_id = '0; ar_fire_len = '0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    endtask

    task automatic do_ar(input logic [IDW-1:0] id, input logic [7:0] len);
        ar_fire = 1'b1; ar_fire_id = id; ar_fire_len = len;
    endtask

    task automatic do_beat(input logic [IDW-1:0] id, input logic [DW-1:0] d,
                           input logic last, input logic [1:0] resp);
        rvalid = 1'b1; rid = id; rdata = d; rlast = last; rresp = resp;
    endtask

    initial begin
        idle();
        out_ready = 1'b1;
        reset = 1'b0;
        tick(); tick();
        $display("txn reset");
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dealloc", dealloc_req, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rready", rready, 1);
        reset = 1'b1;
        tick();

        // Single burst id=3 len=3
        $display("txn single_burst id=3 len=3");
        do_ar(4'd3, 8'd3);
        tick();
        idle();
        chk("sb_outstanding1", outstanding, 1);
        for (int k = 0; k < 4; k++) begin
            do_beat(4'd3, 32'h100 + k, (k == 3), 2'b00);
            tick();
            chk("sb_valid", out_valid, 1);
            chk("sb_data", out_data, 32'h100 + k);
            chk("sb_last", out_last, (k == 3));
            chk("sb_dealloc", dealloc_req, (k == 3));
            chk("sb_err", err_pulse, 0);
        end
        chk("sb_dealloc_id", dealloc_id, 3);
        idle();
        tick();
        chk("sb_drain", out_valid, 0);
        chk("sb_dealloc_off", dealloc_req, 0);
        chk("sb_outstanding0", outstanding, 0);

        // Backpressure id=4 len=3
        $display("txn backpressure id=4 len=3");
        do_ar(4'd4, 8'd3);
        tick();
        idle();
        do_beat(4'd4, 32'hA0, 1'b0, 2'b00);
        tick();
        chk("bp_first", out_data, 32'hA0);
        out_ready = 1'b0;
        do_beat(4'd4, 32'hA1, 1'b0, 2'b00);
        #1;
        chk("bp_rready_low", rready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 32'hA0);
            chk("bp_hold_rready", rready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rready_high", rready, 1);
        tick();
        chk("bp_beat1", out_data, 32'hA1);
        chk("bp_beat1_last", out_last, 0);
        do_beat(4'd4, 32'hA2, 1'b0, 2'b00);
        tick();
        chk("bp_beat2", out_data, 32'hA2);
        do_beat(4'd4, 32'hA3, 1'b1, 2'b00);
        tick();
        chk("bp_beat3", out_data, 32'hA3);
        chk("bp_beat3_last", out_last, 1);
        chk("bp_dealloc", dealloc_req, 1);
        chk("bp_dealloc_id", dealloc_id, 4);
        idle();
        tick();

        // Interleaved ids 1 (len=1) and 2 (len=2)
        $display("txn interleave id=1 len=1 id=2 len=2");
        do_ar(4'd1, 8'd1);
        tick();
        do_ar(4'd2, 8'd2);
        tick();
        idle();
        chk("il_outstanding", outstanding, 2);
        for (int k = 0; k < 5; k++) begin
            do_beat(il_id[k], 32'h200 + k, il_last[k], 2'b00);
            tick();
            chk("il_id", out_id, il_id[k]);
            chk("il_last", out_last, il_last[k]);
            chk("il_dealloc", dealloc_req, il_last[k]);
            if (il_last[k]) chk("il_dealloc_id", dealloc_id, il_id[k]);
            chk("il_err", err_pulse, 0);
        end
        idle();
        tick();
        chk("il_outstanding0", outstanding, 0);

        // Unexpected ID
        $display("txn unexp_id id=7");
        do_beat(4'd7, 32'hDEAD, 1'b1, 2'b00);
        tick();
        idle();
        chk("ux_err", err_pulse, 1);
        chk("ux_code", err_code, 2);
        chk("ux_valid", out_valid, 0);
        chk("ux_dealloc", dealloc_req, 0);
        tick();
        chk("ux_err_off", err_pulse, 0);

        // Early last: len=3, rlast on beat 2
        $display("txn early_last id=6 len=3");
        do_ar(4'd6, 8'd3);
        tick();
        idle();
        do_beat(4'd6, 32'h60, 1'b0, 2'b00);
        tick();
        chk("el_no_err", err_pulse, 0);
        do_beat(4'd6, 32'h61, 1'b1, 2'b00);
        tick();
        idle();
        chk("el_err", err_pulse, 1);
        chk("el_code", err_code, 3);
        chk("el_last", out_last, 0);
        chk("el_dealloc", dealloc_req, 1);
        chk("el_dealloc_id", dealloc_id, 6);

        // Missing last: len=0, rlast=0
        $display("txn missing_last id=8 len=0");
        do_ar(4'd8, 8'd0);
        tick();
        idle();
        do_beat(4'd8, 32'h80, 1'b0, 2'b00);
        tick();
        idle();
        chk("ml_code", err_code, 4);
        chk("ml_last", out_last, 1);
        chk("ml_dealloc", dealloc_req, 1);
        chk("ml_dealloc_id", dealloc_id, 8);

        // Response error: len=0, rresp=2
        $display("txn resp_err id=9 len=0");
        do_ar(4'd9, 8'd0);
        tick();
        idle();
        do_beat(4'd9, 32'h90, 1'b1, 2'b10);
        tick();
        idle();
        chk("re_code", err_code, 5);
        chk("re_out_err", out_err, 1);
        chk("re_dealloc", dealloc_req, 1);

        // ID reuse: overwrite id=10 len=1 with len=0
        $display("txn id_reuse id=10");
        do_ar(4'd10, 8'd1);
        tick();
        do_ar(4'd10, 8'd0);
        tick();
        idle();
        chk("ru_err", err_pulse, 1);
        chk("ru_code", err_code, 1);
        do_beat(4'd10, 32'hA5, 1'b1, 2'b00);
        tick();
        idle();
        chk("ru_last", out_last, 1);
        chk("ru_no_err", err_pulse, 0);
        chk("ru_dealloc", dealloc_req, 1);
        tick();
        chk("ru_outstanding0", outstanding, 0);

        // Completion and new AR on id=5 in the same cycle
        $display("txn same_cycle_reuse id=5");
        do_ar(4'd5, 8'd0);
        tick();
        idle();
        do_beat(4'd5, 32'h50, 1'b1, 2'b00);
        do_ar(4'd5, 8'd0);
        tick();
        idle();
        chk("sc_no_err", err_pulse, 0);
        chk("sc_dealloc", dealloc_req, 1);
        chk("sc_dealloc_id", dealloc_id, 5);
        chk("sc_outstanding", outstanding, 1);

        // Reset mid-burst on id=11
        $display("txn reset_mid_burst id=11");
        do_ar(4'd11, 8'd3);
        tick();
        idle();
        do_beat(4'd11, 32'hB0, 1'b0, 2'b00);
        tick();
        chk("rm_outstanding2", outstanding, 2);
        do_beat(4'd11, 32'hB1, 1'b1, 2'b00);
        reset = 1'b0;
        tick();
        chk("rm_valid", out_valid, 0);
        chk("rm_dealloc", dealloc_req, 0);
        chk("rm_err", err_pulse, 0);
        chk("rm_outstanding", outstanding, 0);
        chk("rm_data", out_data, 0);
        idle();
        tick();
        reset = 1'b1;
        #1;
        chk("rm_rready", rready, 1);
        do_beat(4'd11, 32'hB2, 1'b1, 2'b00);
        tick();
        idle();
        chk("rm_cleared_code", err_code, 2);
        chk("rm_cleared_valid", out_valid, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
